com_bus_deserializer: RTL

- Receiving end of the word stream that feeds the 26-lane common bus.
- Accepts 16-bit words one per handshake and assembles WORD_NUM of them into one packed com_bus_out frame.
- Presents the frame with a valid/ready handshake to the downstream 1-to-26 de-bus stage.
- Sits between a serial producer (memory reader / DMA) and the parallel CNN lane consumers.

---
 rtl/bus_pkg.sv | 14 +
 rtl/com_bus_deserializer_if.sv | 39 +++
 rtl/deser_idx_counter.sv | 30 +++
 rtl/com_bus_deserializer.sv | 88 ++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared common-bus definitions: default lane geometry and deserializer state encoding.
// Also used by the 26-to-1 and 1-to-26 bus blocks.
package bus_pkg;

  localparam int WORD_W_DEF   = 16;
  localparam int WORD_NUM_DEF = 26;
  localparam int BUS_W        = WORD_NUM_DEF * WORD_W_DEF;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/com_bus_deserializer_if.sv
// Word-in / frame-out handshake bundle for com_bus_deserializer.
// word_sof and sof_err exist only when COM_BUS_DESER_SOF_EN is defined.
interface com_bus_deserializer_if #(
  parameter int WORD_W   = 16,
  parameter int WORD_NUM = 26,
  parameter int CNT_W    = 16
);

  logic [WORD_W-1:0]          word_in;
  logic                       word_valid;
  logic                       word_ready;
  logic [WORD_NUM*WORD_W-1:0] com_bus_out;
  logic                       frame_valid;
  logic                       frame_ready;
  logic [CNT_W-1:0]           frame_cnt;
`ifdef COM_BUS_DESER_SOF_EN
  logic                       word_sof;
  logic                       sof_err;
`endif

  modport master (
    output word_in, word_valid, frame_ready,
`ifdef COM_BUS_DESER_SOF_EN
    output word_sof,
    input  sof_err,
`endif
    input  word_ready, com_bus_out, frame_valid, frame_cnt
  );

  modport slave (
    input  word_in, word_valid, frame_ready,
`ifdef COM_BUS_DESER_SOF_EN
    input  word_sof,
    output sof_err,
`endif
    output word_ready, com_bus_out, frame_valid, frame_cnt
  );

endinterface

// File: rtl/deser_idx_counter.sv
// Mod-WORD_NUM slot index counter with increment, load-to-1 and clear.
module deser_idx_counter #(
  parameter  int WORD_NUM = 26,
  localparam int IDX_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_load1,
  input  logic             i_clr,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] r_idx;

  // clear outranks load, load outranks increment
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx <= '0;
    end else if (i_load1) begin
      r_idx <= IDX_W'(1);
    end else if (i_inc) begin
      if (r_idx == IDX_W'(WORD_NUM - 1)) r_idx <= '0;
      else                               r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/com_bus_deserializer.sv
// Assembles WORD_NUM lane words into one com_bus frame with valid/ready on both sides.
// Optional start-of-frame realignment is enabled by defining COM_BUS_DESER_SOF_EN.
module com_bus_deserializer
  import bus_pkg::*;
#(
  parameter  int WORD_W   = WORD_W_DEF,
  parameter  int WORD_NUM = WORD_NUM_DEF,
  parameter  int CNT_W    = 16,
  localparam int FRAME_W  = WORD_NUM * WORD_W,
  localparam int IDX_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  com_bus_deserializer_if.slave  bus
);

  state_t             r_state;
  logic [FRAME_W-1:0] r_bus;
  logic               r_frame_valid;
  logic [CNT_W-1:0]   r_frame_cnt;

  logic               w_word_acc;
  logic               w_frame_del;
  logic               w_sof;
  logic               w_to_slot0;
  logic               w_last;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_slot;

  assign w_word_acc  = bus.word_valid & bus.word_ready;
  assign w_frame_del = r_frame_valid & bus.frame_ready;

`ifdef COM_BUS_DESER_SOF_EN
  logic r_sof_err;
  assign w_sof       = w_word_acc & bus.word_sof;
  assign bus.sof_err = r_sof_err;
`else
  assign w_sof       = 1'b0;
`endif

  // A word accepted in FULL can only coincide with delivery, so it starts the next frame.
  assign w_to_slot0 = w_sof | (r_state == FULL);
  assign w_last     = w_word_acc & (r_state == FILL) & ~w_sof
                    & (w_idx == IDX_W'(WORD_NUM - 1));
  assign w_slot     = w_to_slot0 ? '0 : w_idx;

  deser_idx_counter #(.WORD_NUM(WORD_NUM)) u_idx (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_word_acc & ~w_to_slot0 & ~w_last),
    .i_load1 (w_word_acc & w_to_slot0),
    .i_clr   (w_last),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FILL;
      r_bus         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= '0;
`ifdef COM_BUS_DESER_SOF_EN
      r_sof_err     <= 1'b0;
`endif
    end else begin
      if (w_word_acc) r_bus[w_slot*WORD_W +: WORD_W] <= bus.word_in;
      if (r_state == FILL) begin
        if (w_last) begin
          r_state       <= FULL;
          r_frame_valid <= 1'b1;
        end
      end else if (w_frame_del) begin
        r_state       <= FILL;
        r_frame_valid <= 1'b0;
        r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
      end
`ifdef COM_BUS_DESER_SOF_EN
      r_sof_err <= w_sof & (r_state == FILL) & (w_idx != '0);
`endif
    end
  end

  assign bus.word_ready  = (r_state == FILL) | bus.frame_ready;
  assign bus.com_bus_out = r_bus;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule
